crypto_slot_ctrl: RTL

Parametrised register front-end and job scheduler for an iterative block-cipher core (e.g. the AES-192 engine), placed behind the tile's AXI-lite peripheral decode. It holds NUM_KEY_SLOTS write-only key slots, buffers cipher jobs in an input FIFO, and issues them to the core one at a time with a start/done handshake. Results are collected into an output FIFO. Per-field register locks and debug-mode key masking are supported.

---
 rtl/crypto_slot_ctrl.sv | 260 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/crypto_slot_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : crypto_slot_ctrl                                              |
// | Summary  : Register front-end and job scheduler for an iterative block   |
// |            cipher core. Holds write-only key slots, queues jobs in an    |
// |            input FIFO, issues them with a start/done handshake and       |
// |            collects results in an output FIFO.                           |
// | Options  : CRYPTO_KEY_ZEROIZE_EN - a rising edge of debug_mode_i clears  |
// |            every key slot (otherwise keys are only masked on the output) |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+

module crypto_slot_ctrl #(
    parameter int NUM_KEY_SLOTS = 4,
    parameter int KEY_WORDS     = 6,
    parameter int BLK_WORDS     = 4,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    reg_en_i,
    input  logic                    reg_we_i,
    input  logic [7:0]              reg_addr_i,
    input  logic [31:0]             reg_wdata_i,
    output logic [31:0]             reg_rdata_o,
    input  logic [7:0]              reglk_ctrl_i,
    input  logic                    debug_mode_i,
    output logic                    core_start_o,
    output logic [32*KEY_WORDS-1:0] core_key_o,
    output logic [32*BLK_WORDS-1:0] core_blk_o,
    input  logic                    core_done_i,
    input  logic [32*BLK_WORDS-1:0] core_out_i
);

    localparam int                 c_SLOT_W = (NUM_KEY_SLOTS > 1) ? $clog2(NUM_KEY_SLOTS) : 1;
    localparam int                 c_PTR_W  = $clog2(FIFO_DEPTH);
    localparam int                 c_CNT_W  = c_PTR_W + 1;
    localparam int                 c_BLK_W  = 32 * BLK_WORDS;
    localparam int                 c_KEY_W  = 32 * KEY_WORDS;
    localparam logic [4:0]         c_NSLOT  = 5'(NUM_KEY_SLOTS);
    localparam logic [3:0]         c_NBLK   = 4'(BLK_WORDS);
    localparam logic [3:0]         c_NKEY   = 4'(KEY_WORDS);
    localparam logic [c_CNT_W-1:0] c_FULL   = c_CNT_W'(FIFO_DEPTH);

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_ISSUE = 2'd1;
    localparam logic [1:0] c_S_WAIT  = 2'd2;
    localparam logic [1:0] c_S_DRAIN = 2'd3;

    logic [31:0]         r_key     [NUM_KEY_SLOTS][KEY_WORDS];
    logic [31:0]         r_stg     [BLK_WORDS];
    logic [c_BLK_W-1:0]  r_in_blk  [FIFO_DEPTH];
    logic [c_SLOT_W-1:0] r_in_slot [FIFO_DEPTH];
    logic [c_PTR_W-1:0]  r_in_wr, r_in_rd;
    logic [c_CNT_W-1:0]  r_in_cnt;
    logic [c_BLK_W-1:0]  r_out_blk [FIFO_DEPTH];
    logic [c_PTR_W-1:0]  r_out_wr, r_out_rd;
    logic [c_CNT_W-1:0]  r_out_cnt;
    logic                r_err_ovf, r_err_unf;
    logic [1:0]          r_state;
    logic                r_start;
    logic [c_BLK_W-1:0]  r_job_blk;
    logic [c_SLOT_W-1:0] r_job_slot;

    // Address decode
    logic       w_wr, w_rd;
    logic [2:0] w_word;
    logic [4:0] w_kslot;
    logic       w_is_ctrl, w_is_stat, w_is_stg, w_is_out, w_is_key;

    assign w_wr      = reg_en_i & reg_we_i;
    assign w_rd      = reg_en_i & ~reg_we_i;
    assign w_word    = reg_addr_i[2:0];
    assign w_kslot   = reg_addr_i[7:3] - 5'd4;
    assign w_is_ctrl = (reg_addr_i == 8'h00);
    assign w_is_stat = (reg_addr_i == 8'h01);
    assign w_is_stg  = (reg_addr_i[7:3] == 5'd1) && ({1'b0, w_word} < c_NBLK);
    assign w_is_out  = (reg_addr_i[7:3] == 5'd2) && ({1'b0, w_word} < c_NBLK);
    assign w_is_key  = (reg_addr_i[7:5] != 3'd0) && (w_kslot < c_NSLOT) && ({1'b0, w_word} < c_NKEY);

    // Control-word decode; FLUSH overrides PUSH and POP in the same write
    logic                w_ctrl_wr, w_flush, w_sw_push, w_sw_pop;
    logic                w_in_push, w_out_pop, w_fsm_take, w_out_push;
    logic                w_key_we, w_stg_we, w_zeroize;
    logic [4:0]          w_slot5;
    logic [c_SLOT_W-1:0] w_push_slot;

    assign w_ctrl_wr   = w_wr & w_is_ctrl & ~reglk_ctrl_i[0];
    assign w_flush     = w_ctrl_wr & reg_wdata_i[2];
    assign w_sw_push   = w_ctrl_wr & reg_wdata_i[0] & ~reg_wdata_i[2];
    assign w_sw_pop    = w_ctrl_wr & reg_wdata_i[1] & ~reg_wdata_i[2];
    assign w_in_push   = w_sw_push & (r_in_cnt != c_FULL);
    assign w_out_pop   = w_sw_pop & (r_out_cnt != '0);
    assign w_fsm_take  = (r_state == c_S_IDLE) & (r_in_cnt != '0) & (r_out_cnt != c_FULL) & ~w_flush;
    assign w_out_push  = (r_state == c_S_WAIT) & core_done_i & ~w_flush;
    assign w_key_we    = w_wr & w_is_key & ~reglk_ctrl_i[2];
    assign w_stg_we    = w_wr & w_is_stg & ~reglk_ctrl_i[1];
    assign w_slot5     = 5'(reg_wdata_i[8 +: c_SLOT_W]);
    assign w_push_slot = (w_slot5 < c_NSLOT) ? reg_wdata_i[8 +: c_SLOT_W] : '0;

    logic w_unused_lk;
    assign w_unused_lk = &{1'b0, reglk_ctrl_i[7:5]};

`ifdef CRYPTO_KEY_ZEROIZE_EN
    logic r_dbg_q;

    // Previous debug_mode_i level for rising-edge detection
    always_ff @(posedge clk_i) begin
        if (rst_i) r_dbg_q <= 1'b0;
        else       r_dbg_q <= debug_mode_i;
    end

    assign w_zeroize = debug_mode_i & ~r_dbg_q;
`else
    assign w_zeroize = 1'b0;
`endif

    // Key slot storage; zeroization beats a concurrent key write
    always_ff @(posedge clk_i) begin
        for (int s = 0; s < NUM_KEY_SLOTS; s++) begin
            for (int w = 0; w < KEY_WORDS; w++) begin
                if (rst_i || w_zeroize)
                    r_key[s][w] <= '0;
                else if (w_key_we && (w_kslot == 5'(s)) && (w_word == 3'(w)))
                    r_key[s][w] <= reg_wdata_i;
            end
        end
    end

    // Staging block written word by word
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < BLK_WORDS; i++) begin
            if (rst_i)
                r_stg[i] <= '0;
            else if (w_stg_we && (w_word == 3'(i)))
                r_stg[i] <= reg_wdata_i;
        end
    end

    logic [c_BLK_W-1:0] w_stg_flat;
    logic [c_KEY_W-1:0] w_key_sel;

    // Flatten staging and select the key of the current job
    always_comb begin
        w_stg_flat = '0;
        w_key_sel  = '0;
        for (int i = 0; i < BLK_WORDS; i++)
            w_stg_flat[32*i +: 32] = r_stg[i];
        for (int s = 0; s < NUM_KEY_SLOTS; s++)
            if (r_job_slot == c_SLOT_W'(s))
                for (int w = 0; w < KEY_WORDS; w++)
                    w_key_sel[32*w +: 32] = r_key[s][w];
    end

    // Input FIFO: software push, scheduler pop
    always_ff @(posedge clk_i) begin
        if (rst_i || w_flush) begin
            r_in_wr  <= '0;
            r_in_rd  <= '0;
            r_in_cnt <= '0;
        end else begin
            if (w_in_push) begin
                r_in_blk[r_in_wr]  <= w_stg_flat;
                r_in_slot[r_in_wr] <= w_push_slot;
                r_in_wr            <= r_in_wr + 1'b1;
            end
            if (w_fsm_take)
                r_in_rd <= r_in_rd + 1'b1;
            r_in_cnt <= r_in_cnt + c_CNT_W'(w_in_push) - c_CNT_W'(w_fsm_take);
        end
    end

    // Output FIFO: core result push, software pop
    always_ff @(posedge clk_i) begin
        if (rst_i || w_flush) begin
            r_out_wr  <= '0;
            r_out_rd  <= '0;
            r_out_cnt <= '0;
        end else begin
            if (w_out_push) begin
                r_out_blk[r_out_wr] <= core_out_i;
                r_out_wr            <= r_out_wr + 1'b1;
            end
            if (w_out_pop)
                r_out_rd <= r_out_rd + 1'b1;
            r_out_cnt <= r_out_cnt + c_CNT_W'(w_out_push) - c_CNT_W'(w_out_pop);
        end
    end

    // Sticky error flags; any STATUS write clears them
    always_ff @(posedge clk_i) begin
        if (rst_i || (w_wr && w_is_stat)) begin
            r_err_ovf <= 1'b0;
            r_err_unf <= 1'b0;
        end else begin
            if (w_sw_push && (r_in_cnt == c_FULL)) r_err_ovf <= 1'b1;
            if (w_sw_pop && (r_out_cnt == '0))     r_err_unf <= 1'b1;
        end
    end

    // Job scheduler; a flush while the core owns a job waits for its done in DRAIN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= c_S_IDLE;
            r_start    <= 1'b0;
            r_job_blk  <= '0;
            r_job_slot <= '0;
        end else begin
            r_start <= 1'b0;
            case (r_state)
                c_S_IDLE: begin
                    if (w_fsm_take) begin
                        r_state    <= c_S_ISSUE;
                        r_start    <= 1'b1;
                        r_job_blk  <= r_in_blk[r_in_rd];
                        r_job_slot <= r_in_slot[r_in_rd];
                    end
                end
                c_S_ISSUE: r_state <= w_flush ? c_S_DRAIN : c_S_WAIT;
                c_S_WAIT: begin
                    if (core_done_i)  r_state <= c_S_IDLE;
                    else if (w_flush) r_state <= c_S_DRAIN;
                end
                default: begin
                    if (core_done_i) r_state <= c_S_IDLE;
                end
            endcase
        end
    end

    logic [31:0] w_status;
    logic [31:0] w_rdata;

    assign w_status = {16'b0, 4'(r_out_cnt), 4'(r_in_cnt), 4'b0,
                       r_err_ovf, r_err_unf, (r_state != c_S_IDLE), (r_out_cnt != '0)};

    // Combinational read mux with read locks
    always_comb begin
        w_rdata = '0;
        if (w_rd) begin
            if (w_is_stat && !reglk_ctrl_i[4]) begin
                w_rdata = w_status;
            end else if (w_is_stg) begin
                for (int i = 0; i < BLK_WORDS; i++)
                    if (w_word == 3'(i)) w_rdata = r_stg[i];
            end else if (w_is_out && !reglk_ctrl_i[3] && (r_out_cnt != '0)) begin
                for (int i = 0; i < BLK_WORDS; i++)
                    if (w_word == 3'(i)) w_rdata = r_out_blk[r_out_rd][32*i +: 32];
            end
        end
    end

    assign reg_rdata_o  = w_rdata;
    assign core_start_o = r_start;
    assign core_blk_o   = r_job_blk;
    assign core_key_o   = debug_mode_i ? '0 : w_key_sel;

endmodule

`default_nettype wire
